// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg (package)
// Description : Shared definitions for the 8-bit ALU result path: opcode
//               codes, status-flag bit positions and the flag generator
//               used when a result is captured into the result queue.
// Contents    : OP_* opcode codes, F_* flag indices, alu_flags() helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  // Field widths of a queued entry
  localparam int OP_W    = 3;
  localparam int FLAGS_W = 4;

  // Widest sum the flag helper accepts; callers zero-extend into this.
  localparam int FLAGS_SUM_MAX_W = 64;

  // Opcode codes produced by the ALU
  localparam logic [OP_W-1:0] OP_AND   = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB   = 3'd1;
  localparam logic [OP_W-1:0] OP_SUB_A = 3'd2;
  localparam logic [OP_W-1:0] OP_OR    = 3'd3;
  localparam logic [OP_W-1:0] OP_ANDAB = 3'd4;
  localparam logic [OP_W-1:0] OP_NOT   = 3'd5;
  localparam logic [OP_W-1:0] OP_XOR   = 3'd6;
  localparam logic [OP_W-1:0] OP_XNOR  = 3'd7;  // reserved / spare

  // Bit positions inside the 4-bit flag word {C, Z, N, P}
  localparam int F_C = 3;
  localparam int F_Z = 2;
  localparam int F_N = 1;
  localparam int F_P = 0;

  // Flags for a result. The sum arrives zero-extended to FLAGS_SUM_MAX_W so
  // the zero test and parity are unaffected by the padding; msb selects the
  // real sign bit of the original WIDTH-bit sum.
  function automatic logic [FLAGS_W-1:0] alu_flags(
    input logic [FLAGS_SUM_MAX_W-1:0] sum,
    input logic [5:0]                 msb,
    input logic                       cout
  );
    logic [FLAGS_W-1:0] f;
    f      = '0;
    f[F_C] = cout;
    f[F_Z] = (sum == '0);
    f[F_N] = sum[msb];
    f[F_P] = ^sum;
    return f;
  endfunction

endpackage : alu_pkg

`default_nettype wire

// File: rtl/alu_resq_fifo.sv
// ============================================================================
// Module      : alu_resq_fifo
// Description : Generic synchronous FIFO (storage, pointers, occupancy).
//               Full/empty come from the occupancy counter; pointers wrap
//               modulo DEPTH through their natural AW-bit width. The read
//               port shows the head entry, forced to zero while empty.
// Ports       : clk, rst_n        clock, async active-low reset
//               push_i, wdata_i   write request / data (ignored when full)
//               pop_i             read request (ignored when empty)
//               rdata_o           head entry (0 when empty)
//               full_o, empty_o   status
//               count_o           occupancy 0..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_resq_fifo #(
  parameter  int DW    = 15,
  parameter  int DEPTH = 4,   // power of 2, >= 2
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          pop_i,
  output logic [DW-1:0] rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          w_push, w_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);

  // Requests are qualified here so a full/empty queue can never corrupt state.
  assign w_push = push_i && !full_o;
  assign w_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is read from it while the queue is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Masking with empty makes the head read as zero during and after reset.
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule : alu_resq_fifo

`default_nettype wire

// File: rtl/alu_result_queue.sv
// ============================================================================
// Module      : alu_result_queue
// Description : Downstream stage of the 8-bit ALU. Captures each result
//               ({cout, sum}) with its opcode, derives status flags at push
//               time and buffers the entry in a small FIFO presented to the
//               consumer through a valid/ready handshake. No combinational
//               path exists from in_* to out_*.
// Ports       : clk, rst_n                         clock, async active-low reset
//               in_valid/in_ready                  ALU-side handshake
//               in_op, in_sum, in_cout             ALU result
//               out_valid/out_ready                consumer handshake
//               out_op, out_sum, out_flags{C,Z,N,P} head entry
//               count                              occupancy 0..DEPTH
//               carry_cnt, drop_cnt                only with ALU_RESQ_STATS_EN
// Options     : `define ALU_RESQ_STATS_EN adds saturating 16-bit counters of
//               pushes carrying cout=1 and of cycles with in_valid blocked.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_result_queue
  import alu_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,   // power of 2, >= 2
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    in_op,
  input  logic [WIDTH-1:0]   in_sum,
  input  logic               in_cout,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OP_W-1:0]    out_op,
  output logic [WIDTH-1:0]   out_sum,
  output logic [FLAGS_W-1:0] out_flags,
  output logic [AW:0]        count
`ifdef ALU_RESQ_STATS_EN
  ,
  output logic [15:0]        carry_cnt,
  output logic [15:0]        drop_cnt
`endif
);

  localparam int          DW      = OP_W + WIDTH + FLAGS_W;
  localparam logic [5:0]  MSB_IDX = 6'(WIDTH - 1);

  logic [FLAGS_SUM_MAX_W-1:0] sum_ext;
  logic [FLAGS_W-1:0]         in_flags;
  logic [DW-1:0]              wdata;
  logic [DW-1:0]              rdata;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       push;
  logic                       pop;

  always_comb begin
    sum_ext            = '0;
    sum_ext[WIDTH-1:0] = in_sum;
  end

  assign in_flags = alu_flags(sum_ext, MSB_IDX, in_cout);

  // Entry layout: {op, sum, flags}. The opcode is stored as given, spare
  // codes included.
  assign wdata = {in_op, in_sum, in_flags};

  assign in_ready  = !fifo_full;
  assign out_valid = !fifo_empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  alu_resq_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (wdata),
    .pop_i   (pop),
    .rdata_o (rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count)
  );

  assign out_op    = rdata[DW-1 -: OP_W];
  assign out_sum   = rdata[FLAGS_W +: WIDTH];
  assign out_flags = rdata[FLAGS_W-1:0];

`ifdef ALU_RESQ_STATS_EN
  logic [15:0] carry_cnt_q, carry_cnt_d;
  logic [15:0] drop_cnt_q,  drop_cnt_d;

  always_comb begin
    carry_cnt_d = carry_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (push && in_cout && (carry_cnt_q != 16'hFFFF)) begin
      carry_cnt_d = carry_cnt_q + 16'd1;
    end
    // A blocked cycle counts each time, even if upstream holds the same data.
    if (in_valid && !in_ready && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      carry_cnt_q <= carry_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign carry_cnt = carry_cnt_q;
  assign drop_cnt  = drop_cnt_q;
`endif

endmodule : alu_result_queue

`default_nettype wire

// File: tb/tb_alu_result_queue.sv
// ============================================================================
// Module      : tb_alu_result_queue
// Description : Self-checking bench for alu_result_queue: vector table of
//               single push/read-back cases, hand-written full / simultaneous
//               / wrap / async-reset sequences, and a randomized run compared
//               against a queue-based reference model. Build with
//               ALU_RESQ_STATS_EN defined to also check the stats counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_result_queue;
  import alu_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_op;
  logic [7:0] in_sum;
  logic       in_cout;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_op;
  logic [7:0] out_sum;
  logic [3:0] out_flags;
  logic [2:0] count;
`ifdef ALU_RESQ_STATS_EN
  logic [15:0] carry_cnt;
  logic [15:0] drop_cnt;
`endif

  alu_result_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_sum    (in_sum),
    .in_cout   (in_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_op    (out_op),
    .out_sum   (out_sum),
    .out_flags (out_flags),
    .count     (count)
`ifdef ALU_RESQ_STATS_EN
    ,
    .carry_cnt (carry_cnt),
    .drop_cnt  (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference flags from the arithmetic meaning of each bit: C is the carry,
  // Z a zero result, N the sign bit, P the XOR of all sum bits (odd popcount).
  function automatic logic [3:0] ref_flags(input logic [7:0] s, input logic c);
    return {c, (s == 8'd0), s[7], ($countones(s) % 2 == 1)};
  endfunction

  typedef struct {
    logic [2:0] op;
    logic [7:0] sum;
    logic       cout;
    logic [3:0] flags;
  } vec_t;

  typedef struct {
    logic [2:0] op;
    logic [7:0] sum;
    logic       cout;
  } ent_t;

  vec_t vecs[8];
  ent_t mq[$];

  task automatic drive_idle();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_op     = 3'd0;
    in_sum    = 8'd0;
    in_cout   = 1'b0;
  endtask

  task automatic set_in(input logic [2:0] op, input logic [7:0] s, input logic c);
    in_valid = 1'b1;
    in_op    = op;
    in_sum   = s;
    in_cout  = c;
  endtask

  task automatic check_head(input string nm, input logic [2:0] op,
                            input logic [7:0] s, input logic [3:0] f);
    chk({nm, ".valid"}, 32'(out_valid), 32'd1);
    chk({nm, ".op"},    32'(out_op),    32'(op));
    chk({nm, ".sum"},   32'(out_sum),   32'(s));
    chk({nm, ".flags"}, 32'(out_flags), 32'(f));
  endtask

  task automatic drain_all();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (DEPTH + 1) @(negedge clk);
    out_ready = 1'b0;
    chk("drain.count", 32'(count), 32'd0);
  endtask

  logic [7:0] fill_s[4];
  logic [3:0] fill_f[4];

  initial begin
    // Hand-derived vectors. Zero sum: Z=1 and P=0 since no bits are set.
    vecs[0] = '{OP_AND,   8'h00, 1'b0, 4'b0100};
    vecs[1] = '{OP_SUB,   8'h01, 1'b1, 4'b1001};
    vecs[2] = '{OP_SUB_A, 8'hF0, 1'b0, 4'b0010};
    vecs[3] = '{OP_OR,    8'hFF, 1'b0, 4'b0010};
    vecs[4] = '{OP_ANDAB, 8'h7F, 1'b0, 4'b0001};
    vecs[5] = '{OP_NOT,   8'h80, 1'b1, 4'b1011};
    vecs[6] = '{OP_XOR,   8'h0F, 1'b1, 4'b1000};
    vecs[7] = '{OP_XNOR,  8'h00, 1'b1, 4'b1100};
    fill_s = '{8'hF0, 8'h0F, 8'h39, 8'h93};
    fill_f = '{4'b0010, 4'b0000, 4'b0000, 4'b0010};

    drive_idle();
    rst_n = 1'b0;
    #2;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.in_ready",  32'(in_ready),  32'd1);
    chk("rst.count",     32'(count),     32'd0);
    chk("rst.out_op",    32'(out_op),    32'd0);
    chk("rst.out_sum",   32'(out_sum),   32'd0);
    chk("rst.out_flags", 32'(out_flags), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ---- table: single push, visible next cycle, then pop ----
    for (int i = 0; i < 8; i++) begin
      set_in(vecs[i].op, vecs[i].sum, vecs[i].cout);
      @(negedge clk);
      in_valid = 1'b0;
      check_head($sformatf("vec%0d", i), vecs[i].op, vecs[i].sum, vecs[i].flags);
      chk($sformatf("vec%0d.count", i), 32'(count), 32'd1);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk($sformatf("vec%0d.popped", i), 32'(out_valid), 32'd0);
    end

    // ---- fill to full, extra push ignored, drain in order ----
    for (int i = 0; i < 4; i++) begin
      set_in(3'(i), fill_s[i], 1'b0);
      @(negedge clk);
    end
    chk("full.in_ready", 32'(in_ready), 32'd0);
    chk("full.count",    32'(count),    32'd4);
    set_in(3'd5, 8'hAA, 1'b1);
    @(negedge clk);
    chk("full.extra.count", 32'(count), 32'd4);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_head($sformatf("drain%0d", i), 3'(i), fill_s[i], fill_f[i]);
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("drain.empty", 32'(out_valid), 32'd0);

    // ---- full with push+pop: pop only, push lands next cycle ----
    for (int i = 0; i < 4; i++) begin
      set_in(3'd3, 8'h21 + 8'(i), 1'b0);
      @(negedge clk);
    end
    set_in(3'd6, 8'h55, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("fullpp.count1",   32'(count),    32'd3);
    chk("fullpp.in_ready", 32'(in_ready), 32'd1);
    chk("fullpp.head",     32'(out_sum),  32'h22);
    out_ready = 1'b0;
    @(negedge clk);
    chk("fullpp.count2", 32'(count), 32'd4);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("fullpp.d%0d", i), 32'(out_sum), 32'h22 + 32'(i));
      @(negedge clk);
    end
    check_head("fullpp.last", 3'd6, 8'h55, ref_flags(8'h55, 1'b0));
    @(negedge clk);
    out_ready = 1'b0;

    // ---- half full, push+pop every cycle across pointer wrap ----
    for (int k = 0; k < 2; k++) begin
      set_in(3'd1, 8'h10 + 8'(k), 1'b0);
      @(negedge clk);
    end
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("half%0d.count", k), 32'(count), 32'd2);
      chk($sformatf("half%0d.sum", k), 32'(out_sum), 32'h10 + 32'(k));
      set_in(3'd1, 8'h12 + 8'(k), 1'b0);
      out_ready = 1'b1;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("half.end.count", 32'(count), 32'd2);
    chk("half.end.sum",   32'(out_sum), 32'h1A);
    drain_all();

    // ---- randomized run against a queue model ----
    mq.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic do_push, do_pop;
      ent_t e;
      chk("rnd.count",     32'(count),     32'(mq.size()));
      chk("rnd.out_valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("rnd.in_ready",  32'(in_ready),  32'(mq.size() < DEPTH));
      if (mq.size() != 0) begin
        check_head("rnd", mq[0].op, mq[0].sum, ref_flags(mq[0].sum, mq[0].cout));
      end
      e.op  = 3'($urandom_range(0, 7));
      e.sum = 8'($urandom);
      if ($urandom_range(0, 7) == 0) e.sum = 8'h00;
      e.cout = 1'($urandom);
      in_valid  = ($urandom_range(0, 99) < 55);
      out_ready = ($urandom_range(0, 99) < 45);
      in_op = e.op; in_sum = e.sum; in_cout = e.cout;
      do_push = in_valid && (mq.size() < DEPTH);
      do_pop  = out_ready && (mq.size() != 0);
      @(negedge clk);
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(e);
    end
    drain_all();

    // ---- asynchronous reset between edges with 3 entries held ----
    for (int i = 0; i < 3; i++) begin
      set_in(3'd2, 8'h31 + 8'(i), 1'b1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("arst.pre.count", 32'(count), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.out_valid", 32'(out_valid), 32'd0);
    chk("arst.count",     32'(count),     32'd0);
    chk("arst.in_ready",  32'(in_ready),  32'd1);
    chk("arst.out_sum",   32'(out_sum),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_in(OP_XNOR, 8'h6C, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    check_head("arst.after", OP_XNOR, 8'h6C, 4'b1000);
    chk("arst.after.count", 32'(count), 32'd1);

`ifdef ALU_RESQ_STATS_EN
    // ---- stats counters ----
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("stats.rst.carry", 32'(carry_cnt), 32'd0);
    chk("stats.rst.drop",  32'(drop_cnt),  32'd0);
    for (int i = 0; i < 4; i++) begin
      set_in(3'd1, 8'h40 + 8'(i), (i < 3) ? 1'b1 : 1'b0);
      @(negedge clk);
    end
    set_in(3'd1, 8'h77, 1'b1);
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    chk("stats.carry", 32'(carry_cnt), 32'd3);
    chk("stats.drop",  32'(drop_cnt),  32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_alu_result_queue

`default_nettype wire
